// File: rtl/sm_clk_ctrl_if.sv
// sm_clk_ctrl_if: control and status bundle between the clock sequencer and its host
interface sm_clk_ctrl_if;
    logic [3:0]  devide;
    logic        run;
    logic        stepReq;
    logic        burstReq;
    logic [7:0]  burstLen;
    logic        cpuTick;
    logic        done;
    logic        busy;
    logic [1:0]  state;
    logic [31:0] tickCount;
    modport master (
        output devide, run, stepReq, burstReq, burstLen,
        input  cpuTick, done, busy, state, tickCount
    );
    modport slave (
        input  devide, run, stepReq, burstReq, burstLen,
        output cpuTick, done, busy, state, tickCount
    );
endinterface

// File: rtl/sm_clk_ctrl.sv
// sm_clk_ctrl: CPU tick sequencer (run/step/burst); burst mode built only with SM_CLK_CTRL_BURST_EN
module sm_clk_ctrl #(
    parameter int SHIFT = 16
) (
    input logic          clkIn,
    input logic          rst,
    sm_clk_ctrl_if.slave bus
);
    typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, BURST = 2'd3} state_t;
    state_t      st;
    logic [31:0] pc;
    logic [3:0]  div;
    logic [4:0]  exp_sum;
    logic        tc;
    logic        step_q;
    logic        step_edge;
    assign exp_sum   = 5'(SHIFT) + {1'b0, div};
    assign tc        = pc == (32'd1 << exp_sum) - 32'd1;
    assign step_edge = bus.stepReq & ~step_q;
    assign bus.state = st;
`ifdef SM_CLK_CTRL_BURST_EN
    logic       burst_q;
    logic       burst_edge;
    logic [7:0] rem;
    assign burst_edge = bus.burstReq & ~burst_q;
    // Burst request edge register; reset high so a held request is not an edge
    always_ff @(posedge clkIn) begin
        burst_q <= rst ? 1'b1 : bus.burstReq;
    end
`else
    logic unused_burst;
    assign unused_burst = ^{bus.burstReq, bus.burstLen};
`endif
    // Sequencer FSM: prescaler, divide latch, tick/done/busy generation and tick counter
    always_ff @(posedge clkIn) begin
        if (rst) begin
            st            <= HALT;
            pc            <= '0;
            div           <= '0;
            step_q        <= 1'b1;
            bus.cpuTick   <= 1'b0;
            bus.done      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.tickCount <= '0;
`ifdef SM_CLK_CTRL_BURST_EN
            rem           <= '0;
`endif
        end else begin
            step_q        <= bus.stepReq;
            bus.cpuTick   <= 1'b0;
            bus.done      <= 1'b0;
            bus.tickCount <= bus.tickCount + 32'(bus.cpuTick);
            case (st)
                HALT: begin
                    pc  <= '0;
                    div <= bus.devide;
                    if (bus.run) st <= RUN;
                    else if (step_edge) begin
                        st          <= STEP;
                        bus.cpuTick <= 1'b1;
                        bus.done    <= 1'b1;
                        bus.busy    <= 1'b1;
                    end
`ifdef SM_CLK_CTRL_BURST_EN
                    else if (burst_edge) begin
                        st       <= BURST;
                        rem      <= bus.burstLen;
                        bus.done <= bus.burstLen == 8'd0;
                        bus.busy <= 1'b1;
                    end
`endif
                end
                STEP: begin
                    st       <= bus.run ? RUN : HALT;
                    pc       <= '0;
                    div      <= bus.devide;
                    bus.busy <= 1'b0;
                end
                RUN: begin
                    if (tc) begin
                        bus.cpuTick <= 1'b1;
                        pc          <= '0;
                        div         <= bus.devide;
                        st          <= bus.run ? RUN : HALT;
                    end else if (!bus.run) begin
                        st <= HALT;
                        pc <= '0;
                    end else pc <= pc + 32'd1;
                end
`ifdef SM_CLK_CTRL_BURST_EN
                BURST: begin
                    if (bus.run) begin
                        st       <= RUN;
                        pc       <= '0;
                        div      <= bus.devide;
                        bus.busy <= 1'b0;
                    end else if (rem == 8'd0) begin
                        st       <= HALT;
                        bus.busy <= 1'b0;
                    end else if (tc) begin
                        bus.cpuTick <= 1'b1;
                        pc          <= '0;
                        div         <= bus.devide;
                        rem         <= rem - 8'd1;
                        if (rem == 8'd1) begin
                            bus.done <= 1'b1;
                            st       <= HALT;
                            bus.busy <= 1'b0;
                        end
                    end else pc <= pc + 32'd1;
                end
`endif
                default: st <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_clk_ctrl.sv
// tb_sm_clk_ctrl: self-checking bench for sm_clk_ctrl with SHIFT=2 (P = 4 << devide)
module tb_sm_clk_ctrl;
    typedef struct {int cyc; logic tick; logic done;} ev_t;
    typedef struct {logic [3:0] div; int n; int period;} run_vec_t;
    logic     clk = 1'b0;
    logic     rst = 1'b1;
    int       cyc = 0;
    int       compared = 0;
    int       mismatched = 0;
    int       tc_exp = 0;
    int       c0;
    ev_t      q[$];
    run_vec_t vecs[4];
    sm_clk_ctrl_if b();
    sm_clk_ctrl #(.SHIFT(2)) dut (.clkIn(clk), .rst(rst), .bus(b.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic push(input int c, input logic t, input logic d);
        ev_t e;
        e.cyc = c;
        e.tick = t;
        e.done = d;
        q.push_back(e);
    endtask
    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic check_reset_values();
        chk("rst_state", b.state, 0);
        chk("rst_tick", b.cpuTick, 0);
        chk("rst_done", b.done, 0);
        chk("rst_busy", b.busy, 0);
        chk("rst_tick_count", b.tickCount, 0);
    endtask
    // Scoreboard: every tick or done pulse must match the next expected event
    always @(negedge clk) begin
        if (!rst && (b.cpuTick || b.done)) begin
            if (q.size() == 0) chk("unexpected_event_cycle", cyc, -1);
            else begin
                ev_t e;
                e = q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_tick", b.cpuTick, e.tick);
                chk("event_done", b.done, e.done);
            end
        end
    end
    initial begin
        vecs[0] = '{div: 4'd0, n: 3, period: 4};
        vecs[1] = '{div: 4'd1, n: 2, period: 8};
        vecs[2] = '{div: 4'd2, n: 2, period: 16};
        vecs[3] = '{div: 4'd3, n: 1, period: 32};
        b.devide = 0;
        b.run = 0;
        b.stepReq = 0;
        b.burstReq = 0;
        b.burstLen = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            c0 = cyc;
            b.devide = vecs[i].div;
            b.run = 1;
            for (int k = 1; k <= vecs[i].n; k++) push(c0 + 1 + k * vecs[i].period, 1, 0);
            wait_to(c0 + 2 + vecs[i].n * vecs[i].period);
            tc_exp += vecs[i].n;
            chk("run_tick_count", b.tickCount, tc_exp);
            chk("run_state", b.state, 1);
            b.run = 0;
            wait_to(cyc + 2);
            chk("run_halt_state", b.state, 0);
            chk("run_pending", q.size(), 0);
        end
        c0 = cyc;
        b.stepReq = 1;
        push(c0 + 1, 1, 1);
        wait_to(c0 + 1);
        chk("step_state", b.state, 2);
        chk("step_busy", b.busy, 1);
        wait_to(c0 + 20);
        b.stepReq = 0;
        wait_to(cyc + 2);
        tc_exp += 1;
        chk("step_tick_count", b.tickCount, tc_exp);
        chk("step_end_state", b.state, 0);
        chk("step_end_busy", b.busy, 0);
        chk("step_pending", q.size(), 0);
        c0 = cyc;
        b.devide = 0;
        b.run = 1;
        push(c0 + 5, 1, 0);
        push(c0 + 9, 1, 0);
        push(c0 + 25, 1, 0);
        wait_to(c0 + 7);
        b.devide = 2;
        wait_to(c0 + 26);
        b.run = 0;
        b.devide = 0;
        wait_to(cyc + 3);
        tc_exp += 3;
        chk("div_change_pending", q.size(), 0);
        chk("div_change_tick_count", b.tickCount, tc_exp);
        c0 = cyc;
        b.run = 1;
        push(c0 + 5, 1, 0);
        wait_to(c0 + 4);
        b.run = 0;
        wait_to(c0 + 6);
        tc_exp += 1;
        chk("run_fall_on_tick_state", b.state, 0);
        chk("run_fall_on_tick_count", b.tickCount, tc_exp);
`ifdef SM_CLK_CTRL_BURST_EN
        c0 = cyc;
        b.devide = 1;
        b.burstLen = 3;
        b.burstReq = 1;
        push(c0 + 9, 1, 0);
        push(c0 + 17, 1, 0);
        push(c0 + 25, 1, 1);
        wait_to(c0 + 1);
        chk("burst_state", b.state, 3);
        chk("burst_busy", b.busy, 1);
        wait_to(c0 + 5);
        b.burstReq = 0;
        wait_to(c0 + 26);
        tc_exp += 3;
        chk("burst_end_state", b.state, 0);
        chk("burst_end_busy", b.busy, 0);
        chk("burst_tick_count", b.tickCount, tc_exp);
        chk("burst_pending", q.size(), 0);
        c0 = cyc;
        b.burstLen = 0;
        b.burstReq = 1;
        push(c0 + 1, 0, 1);
        wait_to(c0 + 1);
        chk("burst0_state", b.state, 3);
        wait_to(c0 + 2);
        chk("burst0_end_state", b.state, 0);
        b.burstReq = 0;
        wait_to(cyc + 3);
        chk("burst0_pending", q.size(), 0);
        chk("burst0_tick_count", b.tickCount, tc_exp);
        c0 = cyc;
        b.devide = 0;
        b.burstLen = 5;
        b.burstReq = 1;
        push(c0 + 5, 1, 0);
        push(c0 + 9, 1, 0);
        push(c0 + 14, 1, 0);
        wait_to(c0 + 9);
        b.run = 1;
        b.burstReq = 0;
        wait_to(c0 + 10);
        chk("abort_state", b.state, 1);
        chk("abort_busy", b.busy, 0);
        wait_to(c0 + 15);
        b.run = 0;
        wait_to(cyc + 3);
        tc_exp += 3;
        chk("abort_pending", q.size(), 0);
        chk("abort_tick_count", b.tickCount, tc_exp);
        c0 = cyc;
        b.burstLen = 5;
        b.burstReq = 1;
        push(c0 + 5, 1, 0);
        wait_to(c0 + 6);
        rst = 1;
        wait_to(c0 + 7);
        check_reset_values();
        rst = 0;
        tc_exp = 0;
        wait_to(cyc + 30);
        chk("post_reset_pending", q.size(), 0);
        chk("post_reset_state", b.state, 0);
        chk("post_reset_tick_count", b.tickCount, 0);
        b.burstReq = 0;
`else
        c0 = cyc;
        b.burstLen = 4;
        b.burstReq = 1;
        wait_to(c0 + 2);
        chk("noburst_state", b.state, 0);
        b.burstReq = 0;
        wait_to(cyc + 40);
        chk("noburst_end_state", b.state, 0);
        chk("noburst_done", b.done, 0);
        chk("noburst_tick_count", b.tickCount, tc_exp);
        chk("noburst_pending", q.size(), 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
